// File: rtl/eng_crank_pulse_conditioner.sv
// Crank-tooth pulse conditioner: synchronizes and debounces the raw crank pulse,
// measures tooth-to-tooth period in prescaled ticks and flags a stalled engine.
module eng_crank_pulse_conditioner #(
  parameter int PRESCALE        = 1000,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int STALL_TICKS     = 100
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       crank_in,
  output logic [7:0] out_port
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DEBOUNCE_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]    STALL_LAST    = 8'(STALL_TICKS - 1);
  localparam logic [5:0]    PERIOD_MAX    = 6'd63;

  typedef enum logic [1:0] {
    ST_STALLED,
    ST_FIRST,
    ST_RUNNING
  } state_t;

  logic          sync_1;
  logic          sync_2;
  logic [DW-1:0] db_cnt;
  logic          stable;
  logic          db_done;
  logic          tooth;
  logic [PW-1:0] presc;
  logic          tick;
  logic [7:0]    ticks;
  logic          timeout;
  logic [8:0]    tick_sum;
  logic [5:0]    period_meas;

  state_t        state_reg;
  state_t        state_next;
  logic [5:0]    period_reg;
  logic [5:0]    period_next;
  logic          toggle_reg;
  logic          toggle_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= crank_in;
      sync_2 <= sync_1;
    end
  end

  // Flip on the cycle the mismatch has lasted DEBOUNCE_CYCLES consecutive samples.
  assign db_done = (sync_2 != stable) && (db_cnt == DEBOUNCE_LAST);
  assign tooth   = db_done && !stable;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_cnt <= '0;
      stable <= 1'b0;
    end else if (sync_2 == stable) begin
      db_cnt <= '0;
    end else if (db_done) begin
      db_cnt <= '0;
      stable <= ~stable;
    end else begin
      db_cnt <= db_cnt + DW'(1);
    end
  end

  assign tick    = (presc == PRESCALE_LAST);
  assign timeout = tick && (ticks == STALL_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
      ticks <= '0;
    end else if (tooth) begin
      presc <= '0;
      ticks <= '0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick && ticks != 8'hFF) begin
        ticks <= ticks + 8'd1;
      end
    end
  end

  // A tick landing on the tooth cycle still counts as a whole elapsed tick.
  assign tick_sum    = {1'b0, ticks} + {8'd0, tick};
  assign period_meas = (tick_sum > 9'd63) ? PERIOD_MAX : tick_sum[5:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= ST_STALLED;
      period_reg <= PERIOD_MAX;
      toggle_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      period_reg <= period_next;
      toggle_reg <= toggle_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    period_next = period_reg;
    toggle_next = toggle_reg;
    if (tooth) begin
      toggle_next = ~toggle_reg;
      case (state_reg)
        ST_STALLED: state_next = ST_FIRST;
        default: begin
          state_next  = ST_RUNNING;
          period_next = period_meas;
        end
      endcase
    end else if (timeout && state_reg != ST_STALLED) begin
      state_next  = ST_STALLED;
      period_next = PERIOD_MAX;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port <= 8'hBF;
    end else begin
      out_port <= {state_reg != ST_RUNNING, toggle_reg,
                   (state_reg == ST_RUNNING) ? period_reg : PERIOD_MAX};
    end
  end

endmodule
